// File: rtl/mdp_pkg.sv
// Shared definitions for the multicycle datapath: sequencer states,
// ALU and immediate-format encodings, flag bit positions and register
// file geometry.
package mdp_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_PASSB = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_ZX8    = 2'b00,
        IMM_ZX12   = 2'b01,
        IMM_BRANCH = 2'b10,
        IMM_ZERO   = 2'b11
    } imm_src_t;

    // Positions inside ALUFlags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int NUM_REGS = 16;
    localparam int PC_REG   = 15;

endpackage

// File: rtl/mdp_if.sv
// Unified instruction/data memory port with a req/ack handshake.
//   master (datapath): drives mem_req, mem_we, mem_addr, mem_wdata;
//                      receives mem_rdata, mem_ack.
//   slave  (memory)  : the reverse.
interface mdp_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [PC_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mdp_regfile.sv
// 16 x DATA_W register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-high reset. Reads of R15 return the
// r15 override input instead of the stored value.
//   ra1/ra2 -> rd1/rd2 : read ports
//   we, wa, wd         : write port
//   r15                : value returned for any R15 read
module mdp_regfile
    import mdp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra1,
    input  logic [3:0]        ra2,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: this array is reset as registers, so it maps to flops rather
    // than a RAM macro; the architectural reset state requires all zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // The stored R15 can be written but is never observable.
    assign rd1 = (ra1 == 4'(PC_REG)) ? r15 : regs[ra1];
    assign rd2 = (ra2 == 4'(PC_REG)) ? r15 : regs[ra2];
endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: fetches, decodes, executes, accesses memory and
// writes back one instruction over several cycles through a shared
// req/ack memory port.
//   clk, rst            : clock, asynchronous active-high reset
//   MemtoReg..ALUControl: per-instruction decoder control
//   mem                 : unified memory port (master side)
//   instr               : instruction register, to the decoder
//   ALUFlags            : registered {N,Z,C,V}
//   pc                  : address of the next instruction to fetch
//   retire              : pulse on the last cycle of each instruction
module multicycle_datapath
    import mdp_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg,
    input  logic              ALUSrc,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              PCSrc,
    input  logic [1:0]        ImmSrc,
    input  logic [1:0]        RegSrc,
    input  logic [2:0]        ALUControl,
    mdp_if.master             mem,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        ALUFlags,
    output logic [PC_W-1:0]   pc,
    output logic              retire
);
    // Instruction fields sit up to bit 23; a 32-bit view keeps the field
    // slices legal for narrow DATA_W.
    localparam int IRX_W = (DATA_W < 32) ? 32 : DATA_W;

    state_t            state;
    logic [PC_W-1:0]   ipc;
    logic [DATA_W-1:0] ir, a_reg, b_reg, alu_out, mdr;

    logic [IRX_W-1:0]  ir_x;
    logic              unused_ir_bits;
    logic [3:0]        ra1, ra2;
    logic [PC_W-1:0]   pc_plus8;
    logic [DATA_W-1:0] r15_val, rd1, rd2, ext_imm, src_b, result;
    logic [DATA_W:0]   add_full, sub_full;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;

    assign ir_x           = IRX_W'(ir);
    assign unused_ir_bits = ^ir_x[IRX_W-1:24];

    assign ra1      = RegSrc[0] ? 4'(PC_REG) : ir_x[19:16];
    assign ra2      = RegSrc[1] ? ir_x[15:12] : ir_x[3:0];
    assign pc_plus8 = ipc + PC_W'(8);
    assign r15_val  = DATA_W'(pc_plus8);

    mdp_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (ra1),
        .ra2 (ra2),
        .we  ((state == WB) && RegWrite),
        .wa  (ir_x[15:12]),
        .wd  (result),
        .r15 (r15_val),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        ext_imm = '0;
        case (imm_src_t'(ImmSrc))
            IMM_ZX8:    ext_imm = DATA_W'(ir_x[7:0]);
            IMM_ZX12:   ext_imm = DATA_W'(ir_x[11:0]);
            IMM_BRANCH: ext_imm = DATA_W'($signed({ir_x[23:0], 2'b00}));
            default:    ext_imm = '0;
        endcase
    end

    assign src_b    = ALUSrc ? ext_imm : b_reg;
    assign add_full = {1'b0, a_reg} + {1'b0, src_b};
    // Subtract as A + ~B + 1 so the carry out is the not-borrow flag.
    assign sub_full = {1'b0, a_reg} + {1'b0, ~src_b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (alu_op_t'(ALUControl))
            ALU_ADD: begin
                alu_res           = add_full[DATA_W-1:0];
                alu_flags[FLAG_C] = add_full[DATA_W];
                alu_flags[FLAG_V] = (a_reg[DATA_W-1] == src_b[DATA_W-1]) &&
                                    (alu_res[DATA_W-1] != a_reg[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res           = sub_full[DATA_W-1:0];
                alu_flags[FLAG_C] = sub_full[DATA_W];
                alu_flags[FLAG_V] = (a_reg[DATA_W-1] != src_b[DATA_W-1]) &&
                                    (alu_res[DATA_W-1] != a_reg[DATA_W-1]);
            end
            ALU_AND:   alu_res = a_reg & src_b;
            ALU_ORR:   alu_res = a_reg | src_b;
            ALU_XOR:   alu_res = a_reg ^ src_b;
            ALU_PASSB: alu_res = src_b;
            default:   alu_res = '0;
        endcase
        alu_flags[FLAG_N] = alu_res[DATA_W-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

    assign result = MemtoReg ? mdr : alu_out;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ipc      <= '0;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            ALUFlags <= '0;
        end else begin
            case (state)
                FETCH: if (mem.mem_ack) begin
                    ir    <= mem.mem_rdata;
                    ipc   <= pc;
                    pc    <= pc + PC_W'(4);
                    state <= DECODE;
                end
                DECODE: begin
                    a_reg <= rd1;
                    b_reg <= rd2;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    alu_out  <= alu_res;
                    ALUFlags <= alu_flags;
                    state    <= (MemWrite || MemtoReg) ? MEM : WB;
                end
                MEM: if (mem.mem_ack) begin
                    if (MemWrite) begin
                        state <= FETCH;
                    end else begin
                        mdr   <= mem.mem_rdata;
                        state <= WB;
                    end
                end
                WB: begin
                    if (PCSrc) pc <= {result[PC_W-1:2], 2'b00};
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Bus outputs decode directly from the state register, so they hold
    // steady for the whole wait and show the FETCH request during reset.
    assign mem.mem_req   = (state == FETCH) || (state == MEM);
    assign mem.mem_we    = (state == MEM) && MemWrite;
    assign mem.mem_addr  = (state == MEM) ? alu_out[PC_W-1:0] : pc;
    assign mem.mem_wdata = b_reg;
    assign instr         = ir;
    // A store finishes on its MEM ack, everything else in WB.
    assign retire = (state == WB) || ((state == MEM) && mem.mem_ack && MemWrite);
endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle datapath that executes one instruction over several clock cycles through an internal sequencer. It uses a single shared instruction/data memory port with a req/ack handshake, so the PC, data and register widths are independent of memory latency. It sits between the instruction decoder, which supplies per-instruction control from `instr`, and the unified memory, and it generalises the single-cycle datapath with configurable widths and wait-state tolerance.

## Interface
Parameters:
- `DATA_W`, 32, register, ALU and memory data width.
- `PC_W`, 16, program counter and memory address width. Must satisfy 3 ≤ `PC_W` ≤ `DATA_W`.
- `RESET_PC`, 0, PC value loaded on reset. Must be word aligned.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst`, in, 1, reset; asynchronous and active-high.
- `MemtoReg`, `ALUSrc`, `MemWrite`, `RegWrite`, `PCSrc`, in, 1 each, decoder control for the current instruction. Held stable from DECODE through WB.
- `ImmSrc`, `RegSrc`, in, 2 each, immediate format select and register-read select.
- `ALUControl`, in, 3, ALU operation select.
- `mem_rdata`, in, `DATA_W`, memory read data. Valid in a cycle where `mem_ack`=1.
- `mem_ack`, in, 1, memory completes the current request in this cycle.
- `mem_req`, out, 1, memory request.
- `mem_we`, out, 1, write request qualifier.
- `mem_addr`, out, `PC_W`, memory address.
- `mem_wdata`, out, `DATA_W`, store data.
- `instr`, out, `DATA_W`, instruction register contents, routed to the decoder.
- `ALUFlags`, out, 4, registered flags {N,Z,C,V}.
- `pc`, out, `PC_W`, architectural PC of the next instruction to fetch.
- `retire`, out, 1, one-cycle pulse on the final cycle of each instruction.

## Operation
- Sequencer states:
  - FETCH: drive `mem_req`=1, `mem_addr`=`pc`, `mem_we`=0. Stay until `mem_ack`. On ack: IR←`mem_rdata`, `ipc`←`pc`, `pc`←`pc`+4, go to DECODE.
  - DECODE: A←RF[RA1], B←RF[RA2]. Go to EXECUTE.
  - EXECUTE: ALUOut←ALU(A, SrcB) and `ALUFlags` update. Go to MEM if `MemWrite` or `MemtoReg`, else to WB.
  - MEM: drive `mem_req`=1, `mem_addr`=ALUOut[`PC_W`-1:0], `mem_we`=`MemWrite`, `mem_wdata`=B. Stay until `mem_ack`.
    - Store: on ack, assert `retire` and go to FETCH.
    - Load: on ack, MDR←`mem_rdata` and go to WB.
  - WB: Result = `MemtoReg` ? MDR : ALUOut.
    - If `RegWrite`, RF[IR[15:12]]←Result.
    - If `PCSrc`, `pc`←{Result[`PC_W`-1:2], 2'b00}.
    - Assert `retire` and go to FETCH.
- Register read selection:
  - RA1 = `RegSrc[0]` ? 15 : IR[19:16].
  - RA2 = `RegSrc[1]` ? IR[15:12] : IR[3:0].
  - A read of R15 returns `ipc`+8, zero-extended to `DATA_W`. It never returns the stored R15.
- Immediate extension (ExtImm):
  - `ImmSrc` 00: zero-extend IR[7:0].
  - `ImmSrc` 01: zero-extend IR[11:0].
  - `ImmSrc` 10: sign-extend {IR[23:0],2'b00}.
  - `ImmSrc` 11: zero.
- SrcB = `ALUSrc` ? ExtImm : B.
- ALU operations, with `DATA_W`-bit wrap-around:
  - `ALUControl`: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 XOR, 101 pass SrcB. 110 and 111 return 0.
  - N = result MSB. Z = result is zero.
  - C = carry out for ADD, and not-borrow for SUB. C=0 for logic ops.
  - V = signed overflow for ADD/SUB. V=0 for logic ops.
- `instr` mirrors IR at all times.

## Timing
- Reset values: state FETCH, `pc`=`RESET_PC`, IR=0, A=B=ALUOut=MDR=0, all 16 registers=0, `ALUFlags`=0, `retire`=0.
- While in reset, outputs show the FETCH request: `mem_req`=1, `mem_addr`=`RESET_PC`, `mem_we`=0.
- Latency with zero wait states (ack in the first request cycle):
  - Data-processing or branch: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each cycle of `mem_ack`=0 adds one cycle.
- `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are stable while waiting for ack.
- `mem_ack` is ignored outside FETCH and MEM.
- A write to R15 with `PCSrc`=0 stores the value, but reads of R15 still return `ipc`+8.
- If `PCSrc` and `RegWrite` are both set in WB, both take effect in the same edge.
- `pc` wraps modulo 2^`PC_W`.
- Asynchronous reset in any state, including mid-MEM: the state is abandoned, no register file or memory side effect is committed after assertion, and the sequencer restarts in FETCH.

## Structure
- Package `mdp_pkg` holds:
  - the state enum (FETCH, DECODE, EXECUTE, MEM, WB);
  - `ALUControl` encodings;
  - `ImmSrc` encodings;
  - the flag bit indices.
- One sub-module, `mdp_regfile`: 16×`DATA_W`, two asynchronous read ports, one synchronous write port, asynchronous reset, and an R15 override input.
- ALU, extender and sequencer stay in the top module.

## Test plan
- Reset: pulse `rst` while `mem_ack`=0 → `pc`=0, `mem_req`=1, `mem_addr`=0, `ALUFlags`=0, `retire`=0.
- R1=5, ADD R2,R1,#3 (`ALUSrc`=1, `ImmSrc`=00), immediate ack → R2=8 at WB, `retire` in cycle 4, `pc`=4.
- LDR R3,[R1,#4] with R1=0x20, data ack delayed 2 cycles and `mem_rdata`=0xCAFE → `mem_addr`=0x24, R3=0xCAFE, `retire` in cycle 7.
- STR R2,[R1,#0] with R2=8 → `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=8, no register write, `retire` in cycle 4.
- Branch at `pc`=0 (`RegSrc[0]`=1, `ImmSrc`=10, IR[23:0]=2, ADD, `PCSrc`=1) → `pc`=16.
- SUB 3−5 → `ALUFlags`={1,0,0,0}; SUB 5−5 → {0,1,1,0}; ADD 0x7FFFFFFF+1 → {1,0,0,1}.
- Assert `rst` during MEM of a store → no further write request, `pc`=`RESET_PC`, and the sequencer refetches on release.
